// File: rtl/nios_dut_pio_in_if.sv
// Avalon-MM slave bus bundle for the NIOS DUT input PIO.
// The master drives address/strobes/writedata; the slave returns registered readdata.
interface nios_dut_pio_in_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output read_n,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  read_n,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_dut_pio_in.sv
// Avalon-MM input PIO: synchronises an async bus, exposes its level, captures
// selected edges into a sticky W1C register and raises a masked level interrupt.
module nios_dut_pio_in #(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   nios_dut_pio_in_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic               irq
);

   typedef enum logic [2:0] {
      ADDR_DATA    = 3'd0,
      ADDR_IRQMASK = 3'd2,
      ADDR_EDGECAP = 3'd3
   } reg_addr_e;

   localparam int                CNT_W       = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0]  SETTLE_DONE = CNT_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q,     prev_d;
   logic [WIDTH-1:0] irqmask_q,  irqmask_d;
   logic [WIDTH-1:0] edgecap_q,  edgecap_d;
   logic [CNT_W-1:0] settle_q,   settle_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q,      irq_d;

   logic             wr_en;
   logic             rd_en;
   logic             detect_en;
   logic [WIDTH-1:0] lvl;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] edge_vec;
   logic [WIDTH-1:0] clr_mask;
   logic [31:0]      rd_word;
   logic             unused_wdata;

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign rd_en        = bus.chipselect & ~bus.read_n;
   assign lvl          = sync_q[SYNC_STAGES-1];
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign detect_en    = (settle_q == SETTLE_DONE);
   assign unused_wdata = ^bus.writedata;

   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      case (EDGE_TYPE)
         1:       edge_vec = ~lvl & prev_q;
         2:       edge_vec = lvl ^ prev_q;
         default: edge_vec = lvl & ~prev_q;
      endcase

      // A new capture outranks a write-1-to-clear of the same bit.
      clr_mask  = (wr_en && bus.address == ADDR_EDGECAP) ? wdata : '0;
      edgecap_d = (edgecap_q & ~clr_mask) | (detect_en ? edge_vec : '0);

      irqmask_d = (wr_en && bus.address == ADDR_IRQMASK) ? wdata : irqmask_q;
      prev_d    = lvl;
      settle_d  = detect_en ? settle_q : settle_q + CNT_W'(1);
      irq_d     = |(edgecap_q & irqmask_q);

      rd_word = '0;
      case (bus.address)
         ADDR_DATA:    rd_word[WIDTH-1:0] = lvl;
         ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap_q;
         default:      rd_word = '0;
      endcase
      readdata_d = rd_en ? rd_word : readdata_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the synchroniser array is reset too; otherwise stale X/level
         // data would flow into prev and fake an edge once detection opens.
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         settle_q   <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         prev_q     <= prev_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         settle_q   <= settle_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_nios_dut_pio_in.sv
// Bench for nios_dut_pio_in: three instances (rising/falling/any) share one stimulus
// stream and are compared against a cycle-level behavioural model.
module tb_nios_dut_pio_in;
   localparam int W = 8;
   localparam int S = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          read_n;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   rd_w  [3];
   logic          irq_w [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar t = 0; t < 3; t++) begin : g_dut
      nios_dut_pio_in_if bus ();
      assign bus.address    = address;
      assign bus.chipselect = chipselect;
      assign bus.read_n     = read_n;
      assign bus.write_n    = write_n;
      assign bus.writedata  = writedata;
      assign rd_w[t]        = bus.readdata;

      nios_dut_pio_in #(.WIDTH(W), .EDGE_TYPE(t), .SYNC_STAGES(S)) u_dut (
         .clk     (clk),
         .reset   (reset),
         .bus     (bus.slave),
         .in_port (in_port),
         .irq     (irq_w[t])
      );
   end

   // Behavioural model: lvl is in_port delayed by S edges; per-type capture state.
   logic [W-1:0] m_pipe [$];
   logic [W-1:0] m_lvl  = '0;
   logic [W-1:0] m_prev = '0;
   logic [W-1:0] m_mask = '0;
   logic [W-1:0] m_cap [3];
   logic [31:0]  m_rd  [3];
   logic         m_irq [3];
   int           since = 0;

   task automatic model_step();
      logic [W-1:0] e;
      logic [W-1:0] wd;
      logic [W-1:0] clr;
      bit ws, rs;
      ws  = chipselect && !write_n;
      rs  = chipselect && !read_n;
      wd  = writedata[W-1:0];
      clr = (ws && address == 3'd3) ? wd : '0;
      if (reset) begin
         m_pipe.delete();
         repeat (S - 1) m_pipe.push_back('0);
         m_lvl  = '0;
         m_prev = '0;
         m_mask = '0;
         since  = 0;
         for (int t = 0; t < 3; t++) begin
            m_cap[t] = '0;
            m_rd[t]  = '0;
            m_irq[t] = 1'b0;
         end
         return;
      end
      for (int t = 0; t < 3; t++) begin
         if (t == 0)      e = m_lvl & ~m_prev;
         else if (t == 1) e = ~m_lvl & m_prev;
         else             e = m_lvl ^ m_prev;
         if (rs) begin
            case (address)
               3'd0:    m_rd[t] = 32'(m_lvl);
               3'd2:    m_rd[t] = 32'(m_mask);
               3'd3:    m_rd[t] = 32'(m_cap[t]);
               default: m_rd[t] = 32'd0;
            endcase
         end
         m_irq[t] = |(m_cap[t] & m_mask);
         m_cap[t] = (m_cap[t] & ~clr) | ((since >= S + 1) ? e : '0);
      end
      if (ws && address == 3'd2) m_mask = wd;
      m_prev = m_lvl;
      m_pipe.push_back(in_port);
      m_lvl = m_pipe.pop_front();
      if (since < S + 1) since++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a);
      chipselect = 1'b1; read_n = 1'b0; address = a;
      tick();
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic test_reset();
      in_port = 8'hFF; reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(10);
      bus_read(3'd3);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h0 || rd_w[t] !== m_rd[t]) begin
            n_fail++; $display("FAIL reset_edgecap[%0d]: got %h want 00000000", t, rd_w[t]);
         end
         n_checks++;
         if (irq_w[t] !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq[%0d]: got %b want 0", t, irq_w[t]);
         end
      end
      bus_read(3'd0);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h000000FF || rd_w[t] !== m_rd[t]) begin
            n_fail++; $display("FAIL reset_data[%0d]: got %h want 000000ff", t, rd_w[t]);
         end
      end
   endtask

   task automatic test_rising_irq();
      in_port = 8'h00;
      idle(4);
      bus_write(3'd3, 32'hFF);
      bus_write(3'd2, 32'h01);
      in_port = 8'h01;
      idle(2);
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL rise_irq_early: got %b want 0", irq_w[0]);
      end
      tick();
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL rise_irq_k2: got %b want 0", irq_w[0]);
      end
      tick();
      n_checks++;
      if (irq_w[0] !== 1'b1 || irq_w[0] !== m_irq[0]) begin
         n_fail++; $display("FAIL rise_irq_k3: got %b want 1", irq_w[0]);
      end
      bus_read(3'd3);
      n_checks++;
      if (rd_w[0] !== 32'h01) begin
         n_fail++; $display("FAIL rise_edgecap: got %h want 00000001", rd_w[0]);
      end
      bus_write(3'd3, 32'h01);
      n_checks++;
      if (irq_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL rise_irq_clr_m: got %b want 1", irq_w[0]);
      end
      tick();
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL rise_irq_clr_m1: got %b want 0", irq_w[0]);
      end
   endtask

   task automatic test_set_wins();
      in_port = 8'h09;
      idle(2);
      bus_write(3'd3, 32'h08);
      bus_read(3'd3);
      n_checks++;
      if (rd_w[0] !== 32'h08) begin
         n_fail++; $display("FAIL set_wins: got %h want 00000008", rd_w[0]);
      end
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== m_rd[t]) begin
            n_fail++; $display("FAIL set_wins_model[%0d]: got %h want %h", t, rd_w[t], m_rd[t]);
         end
      end
   endtask

   task automatic test_mask_irq();
      bus_write(3'd2, 32'h00);
      in_port = 8'h00;
      idle(4);
      bus_write(3'd3, 32'hFF);
      in_port = 8'h0C;
      idle(4);
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL mask_irq_masked: got %b want 0", irq_w[0]);
      end
      bus_read(3'd3);
      n_checks++;
      if (rd_w[0] !== 32'h0C) begin
         n_fail++; $display("FAIL mask_edgecap: got %h want 0000000c", rd_w[0]);
      end
      bus_write(3'd2, 32'h04);
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL mask_irq_m: got %b want 0", irq_w[0]);
      end
      tick();
      n_checks++;
      if (irq_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL mask_irq_m1: got %b want 1", irq_w[0]);
      end
      bus_write(3'd3, 32'h04);
      tick();
      n_checks++;
      if (irq_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL mask_irq_cleared: got %b want 0", irq_w[0]);
      end
      bus_read(3'd3);
      n_checks++;
      if (rd_w[0] !== 32'h08) begin
         n_fail++; $display("FAIL mask_edgecap_left: got %h want 00000008", rd_w[0]);
      end
   endtask

   task automatic test_any_edge();
      logic [31:0] exp_up [3];
      logic [31:0] exp_dn [3];
      exp_up = '{32'h80, 32'h00, 32'h80};
      exp_dn = '{32'h00, 32'h80, 32'h80};
      in_port = 8'h00;
      idle(4);
      bus_write(3'd3, 32'hFF);
      in_port = 8'h80;
      idle(4);
      bus_read(3'd3);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== exp_up[t]) begin
            n_fail++; $display("FAIL edge_up[%0d]: got %h want %h", t, rd_w[t], exp_up[t]);
         end
      end
      bus_write(3'd3, 32'hFF);
      in_port = 8'h00;
      idle(4);
      bus_read(3'd3);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== exp_dn[t]) begin
            n_fail++; $display("FAIL edge_dn[%0d]: got %h want %h", t, rd_w[t], exp_dn[t]);
         end
      end
      bus_read(3'd5);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read[%0d]: got %h want 00000000", t, rd_w[t]);
         end
      end
      bus_write(3'd0, 32'h55);
      bus_read(3'd0);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h0) begin
            n_fail++; $display("FAIL data_ro[%0d]: got %h want 00000000", t, rd_w[t]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus_write(3'd2, 32'hFF);
      in_port = 8'hFF;
      idle(4);
      bus_read(3'd3);
      n_checks++;
      if (rd_w[0] !== 32'hFF || irq_w[0] !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset: got %h/%b want 000000ff/1", rd_w[0], irq_w[0]);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h0 || irq_w[t] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset[%0d]: got %h/%b want 00000000/0", t, rd_w[t], irq_w[t]);
         end
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (irq_w[t] !== 1'b0) begin
               n_fail++; $display("FAIL settle_irq[%0d] c%0d: got %b want 0", t, c, irq_w[t]);
            end
         end
      end
      bus_read(3'd3);
      for (int t = 0; t < 3; t++) begin
         n_checks++;
         if (rd_w[t] !== 32'h0) begin
            n_fail++; $display("FAIL settle_edgecap[%0d]: got %h want 00000000", t, rd_w[t]);
         end
      end
      bus_read(3'd2);
      n_checks++;
      if (rd_w[0] !== 32'h0) begin
         n_fail++; $display("FAIL reset_mask: got %h want 00000000", rd_w[0]);
      end
   endtask

   task automatic test_random();
      logic [2:0] addr_pool [6];
      addr_pool = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd1, 3'd6};
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
         address    = addr_pool[$urandom_range(0, 5)];
         writedata  = $urandom;
         chipselect = ($urandom_range(0, 3) != 0);
         read_n     = ($urandom_range(0, 1) == 0);
         write_n    = ($urandom_range(0, 2) != 0);
         tick();
         for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (rd_w[t] !== m_rd[t] || irq_w[t] !== m_irq[t]) begin
               n_fail++;
               $display("FAIL random[%0d] cycle %0d: got rd=%h irq=%b want rd=%h irq=%b",
                        t, c, rd_w[t], irq_w[t], m_rd[t], m_irq[t]);
            end
         end
      end
      reset = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      repeat (S - 1) m_pipe.push_back('0);
      for (int t = 0; t < 3; t++) begin
         m_cap[t] = '0; m_rd[t] = '0; m_irq[t] = 1'b0;
      end
      #1;
      test_reset();
      test_rising_irq();
      test_set_wins();
      test_mask_irq();
      test_any_edge();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
